// File: rtl/branch_predictor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor_pkg
//  Description : Shared opcode / REGIMM rt encodings and the counter reset
//                helper for the branch prediction and resolution unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package branch_predictor_pkg;

    // Conditional branch primary opcodes.
    localparam logic [5:0] EXE_REGIMM = 6'b000001;
    localparam logic [5:0] EXE_BEQ    = 6'b000100;
    localparam logic [5:0] EXE_BNE    = 6'b000101;
    localparam logic [5:0] EXE_BLEZ   = 6'b000110;
    localparam logic [5:0] EXE_BGTZ   = 6'b000111;

    // REGIMM rt field selects the sign-test variant and whether $31 is written.
    localparam logic [4:0] RT_BLTZ    = 5'b00000;
    localparam logic [4:0] RT_BGEZ    = 5'b00001;
    localparam logic [4:0] RT_BLTZAL  = 5'b10000;
    localparam logic [4:0] RT_BGEZAL  = 5'b10001;

    // Weakly not-taken value for a counter of the given width: 2^(w-1)-1.
    function automatic logic [31:0] cnt_reset_val(input int unsigned w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_predictor_resolve.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve
//  Description : Purely combinational branch condition evaluation, link
//                (bsave) detection and non-branch decode for the decode stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve
    import branch_predictor_pkg::*;
(
    input  logic        valid,
    input  logic [5:0]  op,
    input  logic [4:0]  rt,
    input  logic [31:0] h1,
    input  logic [31:0] h2,
    output logic        taken,
    output logic        bsave,
    output logic        is_branch
);

    logic h1_zero;
    logic h1_neg;
    logic link;

    assign h1_zero = (h1 == 32'd0);
    assign h1_neg  = h1[31];

    // Decode op/rt into branch class, outcome and link; anything unknown is a non-branch.
    always_comb begin
        taken     = 1'b0;
        link      = 1'b0;
        is_branch = 1'b0;
        case (op)
            EXE_BEQ: begin
                is_branch = 1'b1;
                taken     = (h1 == h2);
            end
            EXE_BNE: begin
                is_branch = 1'b1;
                taken     = (h1 != h2);
            end
            EXE_BLEZ: begin
                is_branch = 1'b1;
                taken     = h1_neg | h1_zero;
            end
            EXE_BGTZ: begin
                is_branch = 1'b1;
                taken     = ~(h1_neg | h1_zero);
            end
            EXE_REGIMM: begin
                case (rt)
                    RT_BLTZ: begin
                        is_branch = 1'b1;
                        taken     = h1_neg;
                    end
                    RT_BLTZAL: begin
                        is_branch = 1'b1;
                        link      = 1'b1;
                        taken     = h1_neg;
                    end
                    RT_BGEZ: begin
                        is_branch = 1'b1;
                        taken     = ~h1_neg;
                    end
                    RT_BGEZAL: begin
                        is_branch = 1'b1;
                        link      = 1'b1;
                        taken     = ~h1_neg;
                    end
                    default: begin
                        is_branch = 1'b0;
                    end
                endcase
            end
            default: begin
                is_branch = 1'b0;
            end
        endcase
    end

    // The link register is written regardless of outcome, but only for a live branch.
    assign bsave = valid & link;

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor
//  Description : Table of saturating counters indexed from the fetch PC, a
//                registered prediction into decode, branch resolution from
//                forwarded operands, misprediction flag/counter and training.
//                Optional macro BP_GSHARE_EN: XOR a global history register
//                into the table index (gshare); otherwise bimodal.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int IDX_W = 6,
    parameter int CNT_W = 2
)(
    input  logic             clk,
    input  logic             resetn,
    input  logic             f_valid,
    input  logic [PC_W-1:0]  f_pc,
    input  logic             stall,
    input  logic             flush,
    output logic             d_pred_taken,
    output logic [IDX_W-1:0] d_pred_idx,
    input  logic             r_valid,
    input  logic [5:0]       r_op,
    input  logic [4:0]       r_rt,
    input  logic [31:0]      r_h1,
    input  logic [31:0]      r_h2,
    input  logic [IDX_W-1:0] r_idx,
    input  logic             r_pred_taken,
    output logic             r_taken,
    output logic             r_bsave,
    output logic             r_mispredict,
    output logic [31:0]      mispred_cnt
);

    localparam int             DEPTH   = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(cnt_reset_val(CNT_W));
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MIN = {CNT_W{1'b0}};

    logic [CNT_W-1:0] cnt_tbl [DEPTH];
    logic [IDX_W-1:0] pc_idx;
    logic [IDX_W-1:0] lookup_idx;
    logic             lookup_taken;
    logic             is_branch;
    logic             train;
    logic [CNT_W-1:0] cnt_cur;
    logic [CNT_W-1:0] cnt_next;
    logic             unused_pc_bits;

    // Only the word-aligned index bits of the PC feed the lookup.
    assign pc_idx         = f_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{f_pc[PC_W-1:IDX_W+2], f_pc[1:0]};

    branch_resolve u_resolve (
        .valid     (r_valid),
        .op        (r_op),
        .rt        (r_rt),
        .h1        (r_h1),
        .h2        (r_h2),
        .taken     (r_taken),
        .bsave     (r_bsave),
        .is_branch (is_branch)
    );

    assign train        = r_valid & is_branch;
    assign r_mispredict = train & (r_taken != r_pred_taken);

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] ghr;

    // Global history: shift in each resolved outcome; never rolled back on flush.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ghr <= '0;
        end else if (train) begin
            ghr <= {ghr[IDX_W-2:0], r_taken};
        end
    end

    assign lookup_idx = pc_idx ^ ghr;
`else
    assign lookup_idx = pc_idx;
`endif

    // Lookup reads the current table contents, so a same-cycle update is not seen.
    assign lookup_taken = cnt_tbl[lookup_idx][CNT_W-1];

    // Saturating step of the counter named by the index carried with the branch.
    assign cnt_cur = cnt_tbl[r_idx];
    always_comb begin
        cnt_next = cnt_cur;
        if (r_taken) begin
            if (cnt_cur != CNT_MAX) cnt_next = cnt_cur + 1'b1;
        end else begin
            if (cnt_cur != CNT_MIN) cnt_next = cnt_cur - 1'b1;
        end
    end

    // Counter table: whole-table async reinit, one trained entry per resolve.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_tbl[i] <= CNT_RST;
            end
        end else if (train) begin
            cnt_tbl[r_idx] <= cnt_next;
        end
    end

    // Decode prediction register: flush > stall > fetch > drop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            d_pred_taken <= 1'b0;
            d_pred_idx   <= '0;
        end else if (flush) begin
            d_pred_taken <= 1'b0;
            d_pred_idx   <= lookup_idx;
        end else if (stall) begin
            d_pred_taken <= d_pred_taken;
            d_pred_idx   <= d_pred_idx;
        end else if (f_valid) begin
            d_pred_taken <= lookup_taken;
            d_pred_idx   <= lookup_idx;
        end else begin
            d_pred_taken <= 1'b0;
        end
    end

    // Misprediction statistics, sticking at all-ones.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mispred_cnt <= 32'd0;
        end else if (r_mispredict && (mispred_cnt != 32'hFFFF_FFFF)) begin
            mispred_cnt <= mispred_cnt + 32'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predictor
//  Description : Directed-vector bench for branch_predictor. Stimulus pushes
//                hand-computed expectations tagged with the cycle they must be
//                observed in; a monitor on the falling edge pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;
    import branch_predictor_pkg::*;

    localparam int PC_W  = 32;
    localparam int IDX_W = 6;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             resetn;
    logic             f_valid;
    logic [PC_W-1:0]  f_pc;
    logic             stall;
    logic             flush;
    logic             d_pred_taken;
    logic [IDX_W-1:0] d_pred_idx;
    logic             r_valid;
    logic [5:0]       r_op;
    logic [4:0]       r_rt;
    logic [31:0]      r_h1;
    logic [31:0]      r_h2;
    logic [IDX_W-1:0] r_idx;
    logic             r_pred_taken;
    logic             r_taken;
    logic             r_bsave;
    logic             r_mispredict;
    logic [31:0]      mispred_cnt;

    branch_predictor #(.PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .f_valid      (f_valid),
        .f_pc         (f_pc),
        .stall        (stall),
        .flush        (flush),
        .d_pred_taken (d_pred_taken),
        .d_pred_idx   (d_pred_idx),
        .r_valid      (r_valid),
        .r_op         (r_op),
        .r_rt         (r_rt),
        .r_h1         (r_h1),
        .r_h2         (r_h2),
        .r_idx        (r_idx),
        .r_pred_taken (r_pred_taken),
        .r_taken      (r_taken),
        .r_bsave      (r_bsave),
        .r_mispredict (r_mispredict),
        .mispred_cnt  (mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef enum int {S_PRED, S_IDX, S_TAKEN, S_BSAVE, S_MISP, S_MCNT} sig_e;
    typedef struct {
        int          tag;
        sig_e        sig;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t             sb[$];
    int               cyc   = 0;
    int               n_vec = 0;
    int               n_err = 0;
    logic [IDX_W-1:0] ghr_m = '0;
    logic [IDX_W-1:0] held_idx;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] dut_val(input sig_e s);
        case (s)
            S_PRED:  return {31'd0, d_pred_taken};
            S_IDX:   return {26'd0, d_pred_idx};
            S_TAKEN: return {31'd0, r_taken};
            S_BSAVE: return {31'd0, r_bsave};
            S_MISP:  return {31'd0, r_mispredict};
            default: return mispred_cnt;
        endcase
    endfunction

    // Monitor: compare every expectation due this cycle; overdue ones are failures.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].tag <= cyc) begin
                n_vec++;
                if (sb[i].tag < cyc) begin
                    n_err++;
                    $display("FAIL %s: never sampled (due cycle %0d, now %0d)", sb[i].name, sb[i].tag, cyc);
                end else if (dut_val(sb[i].sig) !== sb[i].exp) begin
                    n_err++;
                    $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h",
                             sb[i].name, cyc, dut_val(sb[i].sig), sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    task automatic push(input int tag, input sig_e s, input logic [31:0] e, input string nm);
        exp_t x;
        x.tag  = tag;
        x.sig  = s;
        x.exp  = e;
        x.name = nm;
        sb.push_back(x);
    endtask

    function automatic logic [IDX_W-1:0] exp_idx(input logic [31:0] pc);
        logic [IDX_W-1:0] b;
        b = pc[IDX_W+1:2];
`ifdef BP_GSHARE_EN
        return b ^ ghr_m;
`else
        return b;
`endif
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
        f_valid      = 1'b0;
        f_pc         = '0;
        stall        = 1'b0;
        flush        = 1'b0;
        r_valid      = 1'b0;
        r_op         = '0;
        r_rt         = '0;
        r_h1         = '0;
        r_h2         = '0;
        r_idx        = '0;
        r_pred_taken = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] pc, input bit chk_pred, input bit e_pred, input string nm);
        f_valid = 1'b1;
        f_pc    = pc;
        push(cyc + 1, S_IDX, {26'd0, exp_idx(pc)}, {nm, "_idx"});
        if (chk_pred) push(cyc + 1, S_PRED, {31'd0, e_pred}, {nm, "_pred"});
    endtask

    task automatic resolve(input bit v, input logic [5:0] op, input logic [4:0] rt,
                           input logic [31:0] h1, input logic [31:0] h2,
                           input logic [IDX_W-1:0] idx, input bit pt, input bit isbr,
                           input bit et, input bit eb, input bit em, input string nm);
        r_valid      = v;
        r_op         = op;
        r_rt         = rt;
        r_h1         = h1;
        r_h2         = h2;
        r_idx        = idx;
        r_pred_taken = pt;
        if (v) push(cyc, S_TAKEN, {31'd0, et}, {nm, "_taken"});
        push(cyc, S_BSAVE, {31'd0, eb}, {nm, "_bsave"});
        push(cyc, S_MISP, {31'd0, em}, {nm, "_misp"});
        if (v && isbr) ghr_m = {ghr_m[IDX_W-2:0], et};
    endtask

    initial begin
        resetn = 1'b0;
        f_valid = 1'b0; f_pc = '0; stall = 1'b0; flush = 1'b0;
        r_valid = 1'b0; r_op = '0; r_rt = '0; r_h1 = '0; r_h2 = '0;
        r_idx = '0; r_pred_taken = 1'b0;

        next_cycle();
        push(cyc, S_PRED, 32'd0, "rst_pred");
        push(cyc, S_IDX,  32'd0, "rst_idx");
        push(cyc, S_MCNT, 32'd0, "rst_mcnt");
        next_cycle();
        resetn = 1'b1;

        // Cold lookup and training of entry 4.
        next_cycle(); fetch(32'h0040_0010, 1'b1, 1'b0, "cold");
        next_cycle(); resolve(1, EXE_BEQ, 5'd0, 32'd5, 32'd5, 6'd4, 1, 1, 1, 0, 0, "beq_t1");
        next_cycle(); resolve(1, EXE_BEQ, 5'd0, 32'd5, 32'd5, 6'd4, 1, 1, 1, 0, 0, "beq_t2");
`ifdef BP_GSHARE_EN
        next_cycle(); fetch(32'h0040_0010, 1'b0, 1'b0, "trained");
`else
        next_cycle(); fetch(32'h0040_0010, 1'b1, 1'b1, "trained");
`endif
        next_cycle(); resolve(1, EXE_BEQ, 5'd0, 32'd5, 32'd5, 6'd4, 1, 1, 1, 0, 0, "beq_sat");
        next_cycle(); resolve(1, EXE_BEQ, 5'd0, 32'd5, 32'd6, 6'd4, 0, 1, 0, 0, 0, "beq_nt");
`ifdef BP_GSHARE_EN
        next_cycle(); fetch(32'h0040_0010, 1'b0, 1'b0, "hyst");
`else
        next_cycle(); fetch(32'h0040_0010, 1'b1, 1'b1, "hyst");
`endif

        // Link variants.
        next_cycle(); resolve(1, EXE_REGIMM, RT_BLTZAL, 32'h8000_0000, 32'd0, 6'd10, 1, 1, 1, 1, 0, "bltzal");
        next_cycle(); resolve(1, EXE_REGIMM, RT_BGEZAL, 32'h8000_0000, 32'd0, 6'd11, 0, 1, 0, 1, 0, "bgezal");

        // Misprediction and statistics counter.
        next_cycle();
        push(cyc, S_MCNT, 32'd0, "mcnt_before");
        resolve(1, EXE_BNE, 5'd0, 32'd7, 32'd7, 6'd12, 1, 1, 0, 0, 1, "bne_misp");
        push(cyc + 1, S_MCNT, 32'd1, "mcnt_step");
        next_cycle();
        resolve(0, EXE_BNE, 5'd0, 32'd7, 32'd7, 6'd12, 1, 1, 0, 0, 0, "bne_novalid");
        push(cyc + 1, S_MCNT, 32'd1, "mcnt_novalid");
        next_cycle();
        resolve(1, 6'b000000, 5'd0, 32'd1, 32'd2, 6'd13, 1, 0, 0, 0, 0, "special");
        push(cyc + 1, S_MCNT, 32'd1, "mcnt_nonbr");
        next_cycle();
        resolve(1, EXE_REGIMM, 5'b00010, 32'h8000_0000, 32'd0, 6'd13, 1, 0, 0, 0, 0, "regimm_bad");
        next_cycle();
        resolve(1, EXE_REGIMM, RT_BLTZAL, 32'd1, 32'd0, 6'd13, 1, 1, 0, 1, 1, "bltzal_nt");
        push(cyc + 1, S_MCNT, 32'd2, "mcnt_step2");

        // Condition table.
        next_cycle(); resolve(1, EXE_BLEZ, 5'd0, 32'd0,          32'd0, 6'd20, 1, 1, 1, 0, 0, "blez_zero");
        next_cycle(); resolve(1, EXE_BLEZ, 5'd0, 32'd1,          32'd0, 6'd20, 0, 1, 0, 0, 0, "blez_pos");
        next_cycle(); resolve(1, EXE_BLEZ, 5'd0, 32'hFFFF_FFFF,  32'd0, 6'd20, 1, 1, 1, 0, 0, "blez_neg");
        next_cycle(); resolve(1, EXE_BGTZ, 5'd0, 32'd1,          32'd0, 6'd20, 1, 1, 1, 0, 0, "bgtz_pos");
        next_cycle(); resolve(1, EXE_BGTZ, 5'd0, 32'd0,          32'd0, 6'd20, 0, 1, 0, 0, 0, "bgtz_zero");
        next_cycle(); resolve(1, EXE_BGTZ, 5'd0, 32'h8000_0000,  32'd0, 6'd20, 0, 1, 0, 0, 0, "bgtz_neg");
        next_cycle(); resolve(1, EXE_REGIMM, RT_BLTZ, 32'h8000_0000, 32'd0, 6'd20, 1, 1, 1, 0, 0, "bltz_neg");
        next_cycle(); resolve(1, EXE_REGIMM, RT_BLTZ, 32'd1,         32'd0, 6'd20, 0, 1, 0, 0, 0, "bltz_pos");
        next_cycle(); resolve(1, EXE_REGIMM, RT_BGEZ, 32'd0,         32'd0, 6'd20, 1, 1, 1, 0, 0, "bgez_zero");
        next_cycle(); resolve(1, EXE_REGIMM, RT_BGEZ, 32'hFFFF_FFFF, 32'd0, 6'd20, 0, 1, 0, 0, 0, "bgez_neg");

        // Stall freezes the decode prediction while the fetch PC moves.
        next_cycle();
        held_idx = exp_idx(32'h0040_0010);
`ifdef BP_GSHARE_EN
        fetch(32'h0040_0010, 1'b0, 1'b0, "pre_stall");
`else
        fetch(32'h0040_0010, 1'b1, 1'b1, "pre_stall");
`endif
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            stall   = 1'b1;
            f_valid = 1'b1;
            f_pc    = 32'h0040_0040 + 32'(k * 4);
            push(cyc + 1, S_IDX, {26'd0, held_idx}, "stall_idx");
`ifndef BP_GSHARE_EN
            push(cyc + 1, S_PRED, 32'd1, "stall_pred");
`endif
        end

        // Flush beats fetch and stall; index still follows the lookup.
        next_cycle();
        flush = 1'b1;
        fetch(32'h0040_0010, 1'b1, 1'b0, "flush");
        next_cycle();
        flush = 1'b1;
        stall = 1'b1;
        fetch(32'h0040_0018, 1'b1, 1'b0, "flush_stall");

        // No fetch and no stall drops the prediction.
`ifdef BP_GSHARE_EN
        next_cycle(); fetch(32'h0040_0010, 1'b0, 1'b0, "pre_idle");
`else
        next_cycle(); fetch(32'h0040_0010, 1'b1, 1'b1, "pre_idle");
`endif
        next_cycle();
        push(cyc + 1, S_PRED, 32'd0, "idle_pred");

        // Asynchronous reset mid-run reinitialises table, registers and history.
        next_cycle();
        resetn = 1'b0;
        ghr_m  = '0;
        push(cyc, S_PRED, 32'd0, "arst_pred");
        push(cyc, S_IDX,  32'd0, "arst_idx");
        push(cyc, S_MCNT, 32'd0, "arst_mcnt");
        next_cycle();
        resetn = 1'b1;
        next_cycle(); fetch(32'h0040_0010, 1'b1, 1'b0, "post_rst");
        next_cycle(); resolve(1, EXE_BEQ, 5'd0, 32'd3, 32'd3, 6'd0, 1, 1, 1, 0, 0, "ghr_seed");
        next_cycle(); fetch(32'h0040_0010, 1'b1, 1'b0, "ghr_idx");

        // Same-cycle update and lookup of one entry: lookup sees the old value.
        next_cycle();
        held_idx = exp_idx(32'h0040_0010);
        fetch(32'h0040_0010, 1'b1, 1'b0, "rbw");
        resolve(1, EXE_BEQ, 5'd0, 32'd3, 32'd3, held_idx, 1, 1, 1, 0, 0, "rbw_upd");
`ifndef BP_GSHARE_EN
        next_cycle(); fetch(32'h0040_0010, 1'b1, 1'b1, "rbw_after");
`endif

        repeat (3) next_cycle();
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time bound so a broken clock or stuck process cannot hang the run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
